izh_param_loader: RTL and testbench
===================================

Name: izh_param_loader

Overview:
Byte-serial configuration front end that feeds the Izhikevich neuron core's param_a/b/c/d and params_ready inputs. It accepts commands on an 8-bit valid/ready bus, which maps onto Tiny Tapeout ui_in/uio pins. Commands either select one of four built-in firing-pattern presets or stream a custom 4x16-bit parameter set. All four outputs update atomically from a staging buffer, so the core never integrates with a half-written parameter set.

Parameters:
RESET_PRESET, 0, preset index (0..3) loaded into outputs on reset
AUTO_READY, 1, 1: params_ready=1 after reset; 0: params_ready=0 until first successful load
TIMEOUT_CYCLES, 255, max idle cycles between custom-load bytes before abort (8-bit counter)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
load_valid  input  1  load_data holds a byte this cycle
load_data  input  8  command or payload byte
load_ready  output  1  block accepts a byte when load_valid&&load_ready
param_a  output  16  signed Q8.8 recovery rate a
param_b  output  16  signed Q8.8 sensitivity b
param_c  output  16  signed mV*256 reset potential c
param_d  output  16  signed mV*256 recovery increment d
params_ready  output  1  outputs hold a valid parameter set
commit_pulse  output  1  one-cycle strobe when new parameters take effect
busy  output  1  custom load in progress (state RECV)
error  output  1  sticky: bad header or timeout abort

Behaviour:
- A byte transfers on a posedge with load_valid=1 && load_ready=1. load_ready=1 in IDLE and RECV, and 0 in COMMIT.
- Preset table, values (a,b,c,d) in hex:
  - 0 RS: 0005, 0033, BF00, 0800
  - 1 IB: 0005, 0033, C900, 0400
  - 2 CH: 0005, 0033, CE00, 0200
  - 3 FS: 001A, 0033, BF00, 0200
- Reset values:
  - Params = preset RESET_PRESET.
  - params_ready = AUTO_READY.
  - commit_pulse=0, busy=0, error=0.
  - State=IDLE; staging, byte counter and timeout counter = 0.
- FSM IDLE, header byte accepted:
  - 0xA0..0xA3: go to COMMIT with staging = preset[load_data[1:0]]; clear error.
  - 0xC0: go to RECV with byte count=0 and timeout counter=0; clear error.
  - Any other value: set error, stay IDLE, outputs unchanged.
- FSM RECV:
  - Receive 8 bytes, MSB first, in order a_hi, a_lo, b_hi, b_lo, c_hi, c_lo, d_hi, d_lo, into staging.
  - Each accepted byte increments the count and zeroes the timeout counter.
  - The 8th byte moves the FSM to COMMIT.
  - Each cycle without an accepted byte increments the timeout counter. When it reaches TIMEOUT_CYCLES: set error, discard staging, return to IDLE; outputs and params_ready are unchanged.
  - Header values are not special in RECV; every byte is payload.
- FSM COMMIT (exactly 1 cycle):
  - Copy staging to param_a..d, set params_ready=1, pulse commit_pulse=1, return to IDLE.
  - New values are visible on the cycle after COMMIT.
  - Latency: preset header accepted at cycle N gives new outputs at N+2. The 8th custom byte at N also gives N+2.
- During RECV the old parameters and params_ready are held, so the neuron keeps running uninterrupted.
- busy=1 exactly while state=RECV.
- A load_valid asserted during COMMIT is not accepted; the source must hold the byte.
- Reset mid-RECV: the partial load is discarded and all reset values are restored on the next edge.
- Reset wins over any simultaneous byte transfer.
- error stays set until a valid header (0xA0..0xA3, 0xC0) is accepted, or reset.
- No arithmetic on payload: bytes are concatenated as raw two's-complement 16-bit values.

Test Plan:
- Reset with defaults → param_a/b/c/d = 0005/0033/BF00/0800, params_ready=1, load_ready=1, error=0, busy=0.
- Send header 0xA3 → two cycles later params = 001A/0033/BF00/0200; commit_pulse high for exactly 1 cycle; load_ready=0 during the COMMIT cycle.
- Send 0xC0 then 00 0A 00 40 C0 00 07 00 with random valid gaps under 255 cycles → busy=1 throughout; old params held until commit; then params = 000A/0040/C000/0700.
- Send 0xC0 plus 3 payload bytes, then idle 255 cycles → error=1, busy=0, params unchanged; then send 0xA1 → error=0 and params = 0005/0033/C900/0400.
- Send 0x55 in IDLE → error=1, no commit_pulse, outputs unchanged. Separately, assert reset after 5 payload bytes → reset preset restored, state IDLE, and a following 0xC0 load of 8 bytes commits correctly.
- With AUTO_READY=0: after reset params_ready=0; hold load_valid during COMMIT and check the byte is taken only on the following cycle; params_ready=1 after the first commit.

Source files
------------

// File: rtl/izh_param_loader.sv
// Byte-serial parameter loader for the Izhikevich core. It selects one of four presets or
// streams a custom a/b/c/d set, then commits all four words at once from a staging buffer.
module izh_param_loader #(
    parameter int RESET_PRESET   = 0,
    parameter bit AUTO_READY     = 1'b1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_valid,
    input  logic [7:0]  load_data,
    output logic        load_ready,
    output logic [15:0] param_a,
    output logic [15:0] param_b,
    output logic [15:0] param_c,
    output logic [15:0] param_d,
    output logic        params_ready,
    output logic        commit_pulse,
    output logic        busy,
    output logic        error
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECV   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    // Firing-pattern presets packed as {a, b, c, d}: RS, IB, CH, FS.
    function automatic logic [63:0] preset(input logic [1:0] idx);
        case (idx)
            2'd0:    preset = 64'h0005_0033_BF00_0800;
            2'd1:    preset = 64'h0005_0033_C900_0400;
            2'd2:    preset = 64'h0005_0033_CE00_0200;
            default: preset = 64'h001A_0033_BF00_0200;
        endcase
    endfunction

    state_t      state, next_state;
    logic [63:0] staging;
    logic [2:0]  byte_cnt;
    logic [7:0]  tmo_cnt;
    logic        xfer;
    logic        hdr_preset;
    logic        hdr_custom;

    assign xfer       = load_valid && load_ready;
    assign hdr_preset = (load_data[7:2] == 6'b1010_00);
    assign hdr_custom = (load_data == 8'hC0);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, independent of the order of always blocks.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // NOTE: each combinational output gets a default first so no path infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (xfer && hdr_preset)      next_state = COMMIT;
                else if (xfer && hdr_custom) next_state = RECV;
            end
            RECV: begin
                if (xfer && byte_cnt == 3'd7) next_state = COMMIT;
                else if (!xfer && tmo_cnt == TMO_LAST) next_state = IDLE;
            end
            COMMIT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        load_ready = 1'b1;
        busy       = 1'b0;
        case (state)
            RECV:    busy = 1'b1;
            COMMIT:  load_ready = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            staging      <= '0;
            byte_cnt     <= '0;
            tmo_cnt      <= '0;
            {param_a, param_b, param_c, param_d} <= preset(2'(RESET_PRESET));
            params_ready <= AUTO_READY;
            commit_pulse <= 1'b0;
            error        <= 1'b0;
        end else begin
            commit_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (xfer) begin
                        if (hdr_preset) begin
                            staging <= preset(load_data[1:0]);
                            error   <= 1'b0;
                        end else if (hdr_custom) begin
                            byte_cnt <= '0;
                            tmo_cnt  <= '0;
                            error    <= 1'b0;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    // Payload shifts in MSB first, so after eight bytes a_hi sits on top.
                    if (xfer) begin
                        staging  <= {staging[55:0], load_data};
                        byte_cnt <= byte_cnt + 3'd1;
                        tmo_cnt  <= '0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        staging  <= '0;
                        byte_cnt <= '0;
                        tmo_cnt  <= '0;
                        error    <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                COMMIT: begin
                    {param_a, param_b, param_c, param_d} <= staging;
                    params_ready <= 1'b1;
                    commit_pulse <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_izh_param_loader.sv
// Bench for izh_param_loader: a default instance and an AUTO_READY=0 / preset-2 instance
// share one byte stream and are compared against a transaction-level model of the loader.
module tb_izh_param_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_valid;
    logic [7:0]  load_data;
    logic        load_ready, params_ready, commit_pulse, busy, error;
    logic [15:0] param_a, param_b, param_c, param_d;
    logic        q_load_ready, q_params_ready, q_commit_pulse, q_busy, q_error;
    logic [15:0] q_param_a, q_param_b, q_param_c, q_param_d;

    izh_param_loader dut (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .param_a(param_a), .param_b(param_b),
        .param_c(param_c), .param_d(param_d), .params_ready(params_ready),
        .commit_pulse(commit_pulse), .busy(busy), .error(error)
    );

    izh_param_loader #(.RESET_PRESET(2), .AUTO_READY(1'b0), .TIMEOUT_CYCLES(255)) dut_nr (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
        .load_ready(q_load_ready), .param_a(q_param_a), .param_b(q_param_b),
        .param_c(q_param_c), .param_d(q_param_d), .params_ready(q_params_ready),
        .commit_pulse(q_commit_pulse), .busy(q_busy), .error(q_error)
    );

    always #5 clk = ~clk;

    logic [63:0] tbl [4] = '{64'h0005_0033_BF00_0800, 64'h0005_0033_C900_0400,
                             64'h0005_0033_CE00_0200, 64'h001A_0033_BF00_0200};

    int checks = 0;
    int failures = 0;
    int pulses = 0;
    int q_pulses = 0;

    logic [63:0] exp_p, exp_q;
    bit          exp_ready, exp_qready, exp_err;
    int          exp_pulses;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // All time advances through here; commit_pulse is counted once per cycle it is high.
    task automatic tick();
        @(posedge clk);
        #1;
        if (commit_pulse)   pulses++;
        if (q_commit_pulse) q_pulses++;
    endtask

    task automatic model_reset();
        exp_p = tbl[0];
        exp_q = tbl[2];
        exp_ready = 1'b1;
        exp_qready = 1'b0;
        exp_err = 1'b0;
        exp_pulses = 0;
        pulses = 0;
        q_pulses = 0;
    endtask

    task automatic model_commit(input logic [63:0] v);
        exp_p = v;
        exp_q = v;
        exp_ready = 1'b1;
        exp_qready = 1'b1;
        exp_pulses++;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_params"}, {param_a, param_b, param_c, param_d}, exp_p);
        check({tag, "_q_params"}, {q_param_a, q_param_b, q_param_c, q_param_d}, exp_q);
        check({tag, "_ready"}, 64'(params_ready), 64'(exp_ready));
        check({tag, "_q_ready"}, 64'(q_params_ready), 64'(exp_qready));
        check({tag, "_error"}, 64'(error), 64'(exp_err));
        check({tag, "_q_error"}, 64'(q_error), 64'(exp_err));
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_load_ready"}, 64'(load_ready), 64'd1);
        check({tag, "_pulses"}, 64'(pulses), 64'(exp_pulses));
        check({tag, "_q_pulses"}, 64'(q_pulses), 64'(exp_pulses));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        load_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    // Presents a byte and holds it until the loader takes it; returns 1ns after that edge.
    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        load_valid = 1'b1;
        load_data = b;
        while (!load_ready && waited < 8) begin
            tick();
            waited++;
        end
        check("ready_wait", 64'(load_ready), 64'd1);
        tick();
        load_valid = 1'b0;
        load_data = 8'($urandom);
    endtask

    task automatic do_preset(input logic [1:0] idx);
        send_byte({6'b1010_00, idx});
        exp_err = 1'b0;
        check("preset_commit_ready", 64'(load_ready), 64'd0);
        check("preset_commit_held", {param_a, param_b, param_c, param_d}, exp_p);
        tick();
        model_commit(tbl[idx]);
        check_all("preset");
    endtask

    // long_idx selects one payload byte preceded by the longest gap that must not time out.
    task automatic do_custom(input logic [63:0] v, input int max_gap, input int long_idx);
        send_byte(8'hC0);
        exp_err = 1'b0;
        for (int k = 0; k < 8; k++) begin
            int gap = (k == long_idx) ? 254 : int'($urandom_range(0, max_gap));
            repeat (gap) tick();
            check("recv_busy", 64'(busy), 64'd1);
            check("recv_q_busy", 64'(q_busy), 64'd1);
            check("recv_held", {param_a, param_b, param_c, param_d}, exp_p);
            send_byte(v[63 - 8*k -: 8]);
        end
        tick();
        model_commit(v);
        check_all("custom");
    endtask

    task automatic do_bad(input logic [7:0] b);
        send_byte(b);
        exp_err = 1'b1;
        check_all("bad_hdr");
    endtask

    function automatic logic [7:0] rand_bad();
        logic [7:0] b;
        do b = 8'($urandom);
        while (b[7:2] == 6'b1010_00 || b == 8'hC0);
        return b;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        load_valid = 1'b0;
        load_data = 8'h00;
        do_reset();
        check_all("reset");

        // Preset header with a byte held through the COMMIT cycle: taken one cycle later.
        send_byte(8'hA3);
        load_valid = 1'b1;
        load_data = 8'hA1;
        check("hold_commit_ready", 64'(load_ready), 64'd0);
        check("hold_q_commit_ready", 64'(q_load_ready), 64'd0);
        tick();
        model_commit(tbl[3]);
        check("hold_fs_params", {param_a, param_b, param_c, param_d}, exp_p);
        check("hold_q_ready", 64'(q_params_ready), 64'd1);
        check("hold_idle_ready", 64'(load_ready), 64'd1);
        tick();
        load_valid = 1'b0;
        check("hold_second_commit", 64'(load_ready), 64'd0);
        check("hold_not_early", {param_a, param_b, param_c, param_d}, tbl[3]);
        tick();
        model_commit(tbl[1]);
        check_all("hold");

        do_custom(64'h000A_0040_C000_0700, 20, 3);

        // Three payload bytes then silence: abort on the 255th idle cycle.
        send_byte(8'hC0);
        exp_err = 1'b0;
        for (int k = 0; k < 3; k++) send_byte(8'($urandom));
        repeat (254) tick();
        check("tmo_not_yet_err", 64'(error), 64'd0);
        check("tmo_not_yet_busy", 64'(busy), 64'd1);
        tick();
        exp_err = 1'b1;
        check_all("timeout");
        do_preset(2'd1);

        do_bad(8'h55);

        // Reset mid-load, then a clean custom load.
        send_byte(8'hC0);
        for (int k = 0; k < 5; k++) send_byte(8'($urandom));
        do_reset();
        check_all("mid_reset");
        do_custom({$urandom, $urandom}, 6, 8);

        // Reset together with a valid header: header must be ignored.
        load_valid = 1'b1;
        load_data = 8'hA3;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        load_valid = 1'b0;
        model_reset();
        check_all("reset_wins");

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 2))
                0:       do_preset(2'($urandom));
                1:       do_custom({$urandom, $urandom}, 10, 8);
                default: do_bad(rand_bad());
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
